// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter PUF challenge path: controller FSM encoding and
// the default chain width, so the controller and the mux chain agree on N.
package puf_pkg;

  localparam int PUF_N = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_RESP   = 2'd3
  } puf_state_e;

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchroniser for the asynchronous arbiter latch output.
module puf_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/puf_challenge_ctrl.sv
// Drives a challenge onto the arbiter PUF chain, runs VOTES clear/launch evaluations and
// returns the majority-voted response bit together with the count of evaluations reading 1.
//
//  state  | meaning
//  IDLE   | latch held in reset, waiting for a challenge
//  CLEAR  | latch held in reset for SETTLE_CYCLES
//  LAUNCH | race edge applied for SETTLE_CYCLES+2, sampled on the last cycle
//  RESP   | response presented until the consumer takes it
module puf_challenge_ctrl
  import puf_pkg::*;
#(
  parameter  int N             = PUF_N,
  parameter  int SETTLE_CYCLES = 8,
  parameter  int VOTES         = 5,
  localparam int CW            = $clog2(VOTES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_challenge,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_bit,
  output logic [CW-1:0] rsp_ones,
  output logic [N-1:0]  puf_sel,
  output logic          puf_in,
  output logic          puf_reset,
  input  logic          puf_out
);

  localparam int             CNTW        = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CNTW-1:0] CLEAR_LOAD  = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [CNTW-1:0] LAUNCH_LOAD = CNTW'(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   VOTES_C     = CW'(VOTES);
  localparam logic [CW-1:0]   HALF_C      = CW'(VOTES / 2);

  if ((VOTES % 2) == 0 || SETTLE_CYCLES < 1) begin : g_param_check
    $fatal(1, "puf_challenge_ctrl: VOTES must be odd and SETTLE_CYCLES at least 1");
  end

  puf_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   votes_q, votes_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [N-1:0]    sel_q, sel_d;
  logic            puf_in_q, puf_in_d;
  logic            puf_reset_q, puf_reset_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_bit_q, rsp_bit_d;
  logic [CW-1:0]   rsp_ones_q, rsp_ones_d;
  logic [CW-1:0]   ones_inc, votes_inc;
  logic            sync_out;

  puf_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (puf_out),
    .q     (sync_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    votes_d     = votes_q;
    ones_d      = ones_q;
    sel_d       = sel_q;
    puf_in_d    = puf_in_q;
    puf_reset_d = puf_reset_q;
    rsp_valid_d = rsp_valid_q;
    rsp_bit_d   = rsp_bit_q;
    rsp_ones_d  = rsp_ones_q;
    ones_inc    = ones_q + CW'(sync_out);
    votes_inc   = votes_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          sel_d   = cmd_challenge;
          ones_d  = '0;
          votes_d = '0;
          cnt_d   = CLEAR_LOAD;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == '0) begin
          // launch and latch release switch on the same edge, so they never overlap
          state_d     = ST_LAUNCH;
          cnt_d       = LAUNCH_LOAD;
          puf_reset_d = 1'b0;
          puf_in_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_LAUNCH: begin
        if (cnt_q == '0) begin
          ones_d      = ones_inc;
          votes_d     = votes_inc;
          puf_in_d    = 1'b0;
          puf_reset_d = 1'b1;
          if (votes_inc == VOTES_C) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_ones_d  = ones_inc;
            rsp_bit_d   = (ones_inc > HALF_C);
          end else begin
            state_d = ST_CLEAR;
            cnt_d   = CLEAR_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      votes_q     <= '0;
      ones_q      <= '0;
      sel_q       <= '0;
      puf_in_q    <= 1'b0;
      puf_reset_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_ones_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      votes_q     <= votes_d;
      ones_q      <= ones_d;
      sel_q       <= sel_d;
      puf_in_q    <= puf_in_d;
      puf_reset_q <= puf_reset_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_ones_q  <= rsp_ones_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_bit   = rsp_bit_q;
  assign rsp_ones  = rsp_ones_q;
  assign puf_sel   = sel_q;
  assign puf_in    = puf_in_q;
  assign puf_reset = puf_reset_q;

endmodule
